// File: rtl/gray_to_bayer_expander_pkg.sv
// Shared sizing for the gray-to-Bayer expander: sample width, line geometry
// and coordinate width used by the top and its line RAM.
package gray_to_bayer_expander_pkg;

    localparam int DATA_W  = 12;
    localparam int GRAY_W  = 640;
    localparam int BAYER_W = 2 * GRAY_W;
    localparam int ADDR_W  = 10;
    localparam int COORD_W = 11;

endpackage

// File: rtl/gray_to_bayer_expander_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The bank bit is the address MSB, so both banks decode as a plain concat.
module gray_line_ram
    import gray_to_bayer_expander_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int RAM_DEPTH = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] mem [RAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gray_to_bayer_expander.sv
// Buffers complete 640-pixel gray lines in a ping-pong RAM and replays each
// one as a 1280x960 Bayer row pair (2x2 replication) under CCD_Capture timing.
module gray_to_bayer_expander
    import gray_to_bayer_expander_pkg::*;
(
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSOF,
    input  logic [DATA_W-1:0]  iGray,
    input  logic               iGrayDVAL,
    input  logic               iDVAL,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    output logic [DATA_W-1:0]  oBayer,
    output logic               oDVAL,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont,
    output logic               oUnderflow,
    output logic               oOverrun
);

    logic [ADDR_W-1:0]  wr_col_q,  wr_col_d;
    logic               wr_bank_q, wr_bank_d;
    logic               last_bank_q, last_bank_d;
    logic               line_avail_q, line_avail_d;
    logic               rd_bank_q, rd_bank_d;
    logic               rd_active_q, rd_active_d;
    logic               pair_zero_q, pair_zero_d;
    logic               underflow_q, underflow_d;
    logic               overrun_q, overrun_d;

    logic               dval_s1_q;
    logic [COORD_W-1:0] x_s1_q, y_s1_q;
    logic               zero_s1_q;

    logic [DATA_W-1:0]  bayer_q, bayer_d;
    logic               dval_q;
    logic [COORD_W-1:0] x_q, y_q;

    logic [ADDR_W-1:0]  wr_col_eff;
    logic               line_done;
    logic               rd_latch;
    logic               bank_sel;
    logic               avail_now;
    logic               rd_bank_now;
    logic               zero_now;
    logic               row_end;
    logic               overrun_hit;
    logic [DATA_W-1:0]  ram_rdata;

    // A start-of-frame strobe coinciding with a pixel puts that pixel at column 0.
    assign wr_col_eff  = iSOF ? '0 : wr_col_q;
    assign line_done   = iGrayDVAL && (wr_col_eff == ADDR_W'(GRAY_W - 1));
    assign rd_latch    = iDVAL && (iX_Cont == '0) && !iY_Cont[0];
    assign bank_sel    = line_done ? wr_bank_q : last_bank_q;
    assign avail_now   = (line_avail_q && !iSOF) || line_done;
    assign rd_bank_now = rd_latch ? bank_sel : rd_bank_q;
    assign zero_now    = rd_latch ? !avail_now : (pair_zero_q || !rd_active_q);
    assign row_end     = dval_s1_q && !iDVAL && y_s1_q[0];
    assign overrun_hit = iGrayDVAL && (wr_col_eff == '0) && (wr_bank_q == rd_bank_q) && rd_active_q;

    gray_line_ram u_ram (
        .clk_i   (iCLK),
        .we_i    (iGrayDVAL),
        .waddr_i ({wr_bank_q, wr_col_eff}),
        .wdata_i (iGray),
        .raddr_i ({rd_bank_now, iX_Cont[ADDR_W:1]}),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_col_d     = wr_col_eff;
        wr_bank_d    = wr_bank_q;
        last_bank_d  = last_bank_q;
        line_avail_d = line_avail_q && !iSOF;
        if (iGrayDVAL) begin
            if (line_done) begin
                wr_col_d     = '0;
                last_bank_d  = wr_bank_q;
                wr_bank_d    = !wr_bank_q;
                line_avail_d = 1'b1;
            end else begin
                wr_col_d = wr_col_eff + ADDR_W'(1);
            end
        end

        rd_bank_d   = rd_bank_now;
        rd_active_d = rd_active_q;
        pair_zero_d = pair_zero_q;
        if (rd_latch) begin
            rd_active_d = 1'b1;
            pair_zero_d = !avail_now;
        end else if (row_end) begin
            rd_active_d = 1'b0;
        end

        underflow_d = underflow_q && !iSOF;
        if (rd_latch && !avail_now) begin
            underflow_d = 1'b1;
        end
        overrun_d = overrun_q && !iSOF;
        if (overrun_hit) begin
            overrun_d = 1'b1;
        end

        // Output sample is held between valid beats.
        bayer_d = bayer_q;
        if (dval_s1_q) begin
            bayer_d = zero_s1_q ? '0 : ram_rdata;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_col_q     <= '0;
            wr_bank_q    <= 1'b0;
            last_bank_q  <= 1'b0;
            line_avail_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_active_q  <= 1'b0;
            pair_zero_q  <= 1'b0;
            underflow_q  <= 1'b0;
            overrun_q    <= 1'b0;
            dval_s1_q    <= 1'b0;
            x_s1_q       <= '0;
            y_s1_q       <= '0;
            zero_s1_q    <= 1'b0;
            bayer_q      <= '0;
            dval_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            wr_col_q     <= wr_col_d;
            wr_bank_q    <= wr_bank_d;
            last_bank_q  <= last_bank_d;
            line_avail_q <= line_avail_d;
            rd_bank_q    <= rd_bank_d;
            rd_active_q  <= rd_active_d;
            pair_zero_q  <= pair_zero_d;
            underflow_q  <= underflow_d;
            overrun_q    <= overrun_d;
            dval_s1_q    <= iDVAL;
            x_s1_q       <= iX_Cont;
            y_s1_q       <= iY_Cont;
            zero_s1_q    <= zero_now;
            bayer_q      <= bayer_d;
            dval_q       <= dval_s1_q;
            x_q          <= x_s1_q;
            y_q          <= y_s1_q;
        end
    end

    assign oBayer     = bayer_q;
    assign oDVAL      = dval_q;
    assign oX_Cont    = x_q;
    assign oY_Cont    = y_q;
    assign oUnderflow = underflow_q;
    assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_gray_to_bayer_expander.sv
// Directed bench for gray_to_bayer_expander: line write, row-pair replay,
// underflow/overrun flags, latch bypass, partial-line discard and reset.
module tb_gray_to_bayer_expander;
    import gray_to_bayer_expander_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sof = 1'b0;
    logic [DATA_W-1:0]  gray = '0;
    logic               gdval = 1'b0;
    logic               dval = 1'b0;
    logic [COORD_W-1:0] x = '0;
    logic [COORD_W-1:0] y = '0;
    logic [DATA_W-1:0]  o_bayer;
    logic               o_dval;
    logic [COORD_W-1:0] o_x, o_y;
    logic               o_under, o_over;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gray_to_bayer_expander dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iSOF       (sof),
        .iGray      (gray),
        .iGrayDVAL  (gdval),
        .iDVAL      (dval),
        .iX_Cont    (x),
        .iY_Cont    (y),
        .oBayer     (o_bayer),
        .oDVAL      (o_dval),
        .oX_Cont    (o_x),
        .oY_Cont    (o_y),
        .oUnderflow (o_under),
        .oOverrun   (o_over)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; sof = 1'b0; gdval = 1'b0; gray = '0; dval = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_sof();
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic write_line(input int n, input bit ramp, input logic [DATA_W-1:0] v, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            gdval = 1'b1;
            gray  = ramp ? DATA_W'(i) : v;
            sof   = sof_first && (i == 0);
        end
        @(negedge clk);
        gdval = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic exp_under, input logic exp_over);
        n_vec++;
        if (o_under !== exp_under) begin
            n_err++;
            $display("FAIL %s underflow: got %b expected %b", name, o_under, exp_under);
        end
        n_vec++;
        if (o_over !== exp_over) begin
            n_err++;
            $display("FAIL %s overrun: got %b expected %b", name, o_over, exp_over);
        end
    endtask

    // One Bayer row (1280 valid beats then blanking); optional concurrent gray strobes.
    task automatic drive_row(input int yy, input bit chk, input bit ramp, input logic [DATA_W-1:0] v,
                             input int gray_n, input logic [DATA_W-1:0] gray_v);
        logic              e_dval [$];
        logic [DATA_W-1:0] e_data [$];
        int                e_x    [$];
        logic              ed;
        logic [DATA_W-1:0] edat;
        int                ex;
        logic [DATA_W-1:0] last_d;
        bit                have_last;
        have_last = 1'b0;
        last_d    = '0;
        for (int c = 0; c < BAYER_W + 6; c++) begin
            @(negedge clk);
            if (e_dval.size() == 2) begin
                ed = e_dval.pop_front(); edat = e_data.pop_front(); ex = e_x.pop_front();
                n_vec++;
                if (o_dval !== ed) begin
                    n_err++;
                    $display("FAIL row%0d dval @%0d: got %b expected %b", yy, c, o_dval, ed);
                end
                if (ed) begin
                    n_vec++;
                    if (o_x !== COORD_W'(ex) || o_y !== COORD_W'(yy)) begin
                        n_err++;
                        $display("FAIL row%0d coord: got x=%0d y=%0d expected x=%0d y=%0d", yy, o_x, o_y, ex, yy);
                    end
                end
                if (ed && chk) begin
                    n_vec++;
                    if (o_bayer !== edat) begin
                        n_err++;
                        $display("FAIL row%0d bayer x=%0d: got %0h expected %0h", yy, ex, o_bayer, edat);
                    end
                    last_d = edat;
                    have_last = 1'b1;
                end else if (!ed && chk && have_last) begin
                    n_vec++;
                    if (o_bayer !== last_d) begin
                        n_err++;
                        $display("FAIL row%0d bayer hold: got %0h expected %0h", yy, o_bayer, last_d);
                    end
                end
            end
            y = COORD_W'(yy);
            if (c < BAYER_W) begin
                dval = 1'b1;
                x    = COORD_W'(c);
                e_dval.push_back(1'b1);
                e_data.push_back(ramp ? DATA_W'(c / 2) : v);
                e_x.push_back(c);
            end else begin
                dval = 1'b0;
                x    = '0;
                e_dval.push_back(1'b0);
                e_data.push_back('0);
                e_x.push_back(0);
            end
            gdval = (c < gray_n);
            gray  = gray_v;
        end
        gdval = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (o_bayer !== '0) begin n_err++; $display("FAIL reset bayer: got %0h expected 0", o_bayer); end
        n_vec++; if (o_dval !== 1'b0) begin n_err++; $display("FAIL reset dval: got %b expected 0", o_dval); end
        n_vec++; if (o_x !== '0) begin n_err++; $display("FAIL reset x: got %0d expected 0", o_x); end
        n_vec++; if (o_y !== '0) begin n_err++; $display("FAIL reset y: got %0d expected 0", o_y); end
        check_flags("reset", 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_underflow();
        apply_reset();
        drive_row(0, 1'b1, 1'b0, '0, 0, '0);
        drive_row(1, 1'b1, 1'b0, '0, 0, '0);
        check_flags("underflow set", 1'b1, 1'b0);
        pulse_sof();
        check_flags("underflow sof clear", 1'b0, 1'b0);
    endtask

    task automatic test_ramp();
        apply_reset();
        write_line(GRAY_W, 1'b1, '0, 1'b0);
        drive_row(0, 1'b1, 1'b1, '0, 0, '0);
        drive_row(1, 1'b1, 1'b1, '0, 0, '0);
        check_flags("ramp", 1'b0, 1'b0);
    endtask

    task automatic test_pingpong();
        apply_reset();
        write_line(GRAY_W, 1'b0, 12'h100, 1'b0);
        drive_row(2, 1'b1, 1'b0, 12'h100, GRAY_W, 12'h200);
        drive_row(3, 1'b1, 1'b0, 12'h100, 0, '0);
        check_flags("pingpong pair A", 1'b0, 1'b0);
        drive_row(4, 1'b1, 1'b0, 12'h200, 0, '0);
        drive_row(5, 1'b1, 1'b0, 12'h200, 0, '0);
        check_flags("pingpong pair B", 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        apply_reset();
        write_line(GRAY_W, 1'b0, 12'h100, 1'b0);
        drive_row(0, 1'b1, 1'b0, 12'h100, GRAY_W, 12'h200);
        check_flags("overrun after B", 1'b0, 1'b0);
        write_line(1, 1'b0, 12'h300, 1'b0);
        check_flags("overrun at C", 1'b0, 1'b1);
        pulse_sof();
        check_flags("overrun sof clear", 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        apply_reset();
        write_line(GRAY_W, 1'b0, 12'h111, 1'b0);
        write_line(GRAY_W - 1, 1'b0, 12'h222, 1'b0);
        drive_row(0, 1'b1, 1'b0, 12'h222, 1, 12'h222);
        drive_row(1, 1'b1, 1'b0, 12'h222, 0, '0);
        check_flags("bypass", 1'b0, 1'b0);
    endtask

    task automatic test_partial_sof();
        apply_reset();
        write_line(300, 1'b0, 12'h555, 1'b0);
        write_line(GRAY_W, 1'b0, 12'hABC, 1'b1);
        drive_row(0, 1'b1, 1'b0, 12'hABC, 0, '0);
        drive_row(1, 1'b1, 1'b0, 12'hABC, 0, '0);
        check_flags("partial sof", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        write_line(GRAY_W, 1'b0, 12'hABC, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dval = 1'b1; x = COORD_W'(i); y = '0;
        end
        @(negedge clk);
        n_vec++;
        if (o_dval !== 1'b1 || o_bayer !== 12'hABC) begin
            n_err++;
            $display("FAIL midreset pre: got dval=%b bayer=%0h expected dval=1 bayer=abc", o_dval, o_bayer);
        end
        rst = 1'b1;
        #1;
        n_vec++; if (o_bayer !== '0) begin n_err++; $display("FAIL midreset bayer: got %0h expected 0", o_bayer); end
        n_vec++; if (o_dval !== 1'b0) begin n_err++; $display("FAIL midreset dval: got %b expected 0", o_dval); end
        n_vec++; if (o_x !== '0 || o_y !== '0) begin n_err++; $display("FAIL midreset coord: got %0d/%0d expected 0/0", o_x, o_y); end
        @(negedge clk);
        dval = 1'b0; x = '0;
        @(negedge clk);
        rst = 1'b0;
        drive_row(0, 1'b1, 1'b0, '0, 0, '0);
        check_flags("after midreset", 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_ramp();
        test_pingpong();
        test_overrun();
        test_bypass();
        test_partial_sof();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
